// File: rtl/opc5ls_intc.sv
// OPC5LS interrupt controller: per-source sync/pending slices, mask/mode regs,
// lowest-index priority, registered active-low int_b. Optional macro: OPC5LS_INTC_SOFTSET_EN.

module opc5ls_intc_src (
    input  logic clk,
    input  logic reset_b,
    input  logic irq,
    input  logic edge_mode,
    input  logic clr,
    input  logic set,
    output logic pend
);
    logic [2:0] sync;
    logic       rise;
    logic       pend_nxt;

    assign rise = sync[1] & ~sync[2];

    // In edge mode a set (hardware edge or software) beats a same-cycle clear.
    always_comb begin
        if (edge_mode) pend_nxt = rise | set | (pend & ~clr);
        else           pend_nxt = set | sync[1];
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            sync <= '0;
            pend <= 1'b0;
        end else begin
            sync <= {sync[1:0], irq};
            pend <= pend_nxt;
        end
    end
endmodule

module opc5ls_intc #(
    parameter int          NSRC      = 8,
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic            clk,
    input  logic            reset_b,
    input  logic            clken,
    input  logic [15:0]     address,
    input  logic [15:0]     wdata,
    input  logic            rnw,
    input  logic            vda,
    output logic [15:0]     rdata,
    output logic            rsel,
    input  logic [NSRC-1:0] irq_src,
    output logic            int_b
);
    logic            sel;
    logic            we;
    logic [2:0]      off;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] mode;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] set;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] active;
    logic            id_valid;
    logic [3:0]      id_idx;
    logic            unused_wdata;

    assign sel = vda && (address[15:3] == BASE_ADDR[15:3]);
    assign off = address[2:0];
    assign we  = clken && sel && !rnw;
    assign unused_wdata = &{1'b0, wdata[15:NSRC]};

    assign clr = (we && off == 3'd0) ? wdata[NSRC-1:0] : '0;
`ifdef OPC5LS_INTC_SOFTSET_EN
    assign set = (we && off == 3'd4) ? wdata[NSRC-1:0] : '0;
`else
    assign set = '0;
`endif

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            mask <= '0;
            mode <= '1;
        end else begin
            if (we && off == 3'd1) mask <= wdata[NSRC-1:0];
            if (we && off == 3'd2) mode <= wdata[NSRC-1:0];
        end
    end

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        opc5ls_intc_src u_src (
            .clk       (clk),
            .reset_b   (reset_b),
            .irq       (irq_src[g]),
            .edge_mode (mode[g]),
            .clr       (clr[g]),
            .set       (set[g]),
            .pend      (pending[g])
        );
    end

    assign active = pending & mask;

    // Scan downward so the lowest-numbered active source is the last to win.
    always_comb begin
        id_valid = 1'b0;
        id_idx   = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                id_valid = 1'b1;
                id_idx   = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) int_b <= 1'b1;
        else          int_b <= ~(|active);
    end

    assign rsel = sel && rnw;

    always_comb begin
        rdata = '0;
        if (rsel) begin
            case (off)
                3'd0:    rdata[NSRC-1:0] = pending;
                3'd1:    rdata[NSRC-1:0] = mask;
                3'd2:    rdata[NSRC-1:0] = mode;
                3'd3:    rdata = {id_valid, 11'd0, id_idx};
                default: rdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_opc5ls_intc.sv
// Directed + random bench for opc5ls_intc against a cycle-level behavioural model.
module tb_opc5ls_intc;
    localparam int          NSRC = 8;
    localparam logic [15:0] BASE = 16'hFF00;

    logic            clk = 1'b0;
    logic            reset_b = 1'b0;
    logic            clken = 1'b1;
    logic [15:0]     address = '0;
    logic [15:0]     wdata = '0;
    logic            rnw = 1'b1;
    logic            vda = 1'b0;
    logic [15:0]     rdata;
    logic            rsel;
    logic [NSRC-1:0] irq_src = '0;
    logic            int_b;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [NSRC-1:0] m_pend, m_mask, m_mode;
    logic            m_intb;
    logic [NSRC-1:0] m_smp [3];   // raw source samples from the last three edges

    opc5ls_intc #(.NSRC(NSRC), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset_b(reset_b), .clken(clken), .address(address),
        .wdata(wdata), .rnw(rnw), .vda(vda), .rdata(rdata), .rsel(rsel),
        .irq_src(irq_src), .int_b(int_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_mode = '1; m_intb = 1'b1;
        for (int k = 0; k < 3; k++) m_smp[k] = '0;
    endtask

    function automatic logic [15:0] exp_id();
        for (int i = 0; i < NSRC; i++)
            if (m_pend[i] && m_mask[i]) return 16'h8000 | 16'(i);
        return 16'h0000;
    endfunction

    function automatic logic [15:0] exp_rd(input logic [2:0] o);
        case (o)
            3'd0: return 16'(m_pend);
            3'd1: return 16'(m_mask);
            3'd2: return 16'(m_mode);
            3'd3: return exp_id();
            default: return 16'h0000;
        endcase
    endfunction

    // Advance one clock; model uses the inputs the DUT sees at this edge.
    task automatic tick();
        logic            we;
        logic [2:0]      o;
        logic [NSRC-1:0] clr, set, lvl, prv, np, nmask, nmode;
        logic            nint;
        we  = clken && vda && !rnw && (address[15:3] == BASE[15:3]);
        o   = address[2:0];
        clr = (we && o == 3'd0) ? wdata[NSRC-1:0] : '0;
        set = '0;
`ifdef OPC5LS_INTC_SOFTSET_EN
        if (we && o == 3'd4) set = wdata[NSRC-1:0];
`endif
        lvl = m_smp[1];   // synchronised level lags the raw input by two edges
        prv = m_smp[2];
        for (int i = 0; i < NSRC; i++) begin
            if (m_mode[i]) np[i] = (lvl[i] && !prv[i]) || set[i] || (m_pend[i] && !clr[i]);
            else           np[i] = set[i] || lvl[i];
        end
        nint  = !(|(m_pend & m_mask));
        nmask = (we && o == 3'd1) ? wdata[NSRC-1:0] : m_mask;
        nmode = (we && o == 3'd2) ? wdata[NSRC-1:0] : m_mode;
        @(posedge clk);
        m_smp[2] = m_smp[1]; m_smp[1] = m_smp[0]; m_smp[0] = irq_src;
        m_pend = np; m_intb = nint; m_mask = nmask; m_mode = nmode;
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] o, input logic [15:0] d);
        address = BASE | 16'(o); wdata = d; rnw = 1'b0; vda = 1'b1;
        tick();
        vda = 1'b0; rnw = 1'b1;
    endtask

    // Read check against model, then a clock so timing stays aligned.
    task automatic rd(input string tag, input logic [2:0] o);
        address = BASE | 16'(o); rnw = 1'b1; vda = 1'b1;
        #1;
        chk(tag, rdata, exp_rd(o));
        chk({tag, "_rsel"}, {15'd0, rsel}, 16'd1);
        tick();
        vda = 1'b0;
    endtask

    task automatic rd_lit(input string tag, input logic [2:0] o, input logic [15:0] lit);
        address = BASE | 16'(o); rnw = 1'b1; vda = 1'b1;
        #1;
        chk(tag, rdata, lit);
        tick();
        vda = 1'b0;
    endtask

    task automatic chk_int(input string tag);
        chk(tag, {15'd0, int_b}, {15'd0, m_intb});
    endtask

    initial begin
        logic [15:0] r;
        model_reset();
        repeat (3) @(negedge clk);
        reset_b = 1'b1;

        // Reset state
        chk("rst_int_b", {15'd0, int_b}, 16'd1);
        rd_lit("rst_pend", 3'd0, 16'h0000);
        rd_lit("rst_mask", 3'd1, 16'h0000);
        rd_lit("rst_mode", 3'd2, 16'h00FF);
        rd_lit("rst_id",   3'd3, 16'h0000);
        #1;
        chk("unsel_rdata", rdata, 16'h0000);
        chk("unsel_rsel", {15'd0, rsel}, 16'd0);
        @(negedge clk);
        tick();

        // Edge interrupt on source 2: int_b low after the fourth edge
        wr(3'd1, 16'h0004);
        irq_src[2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) irq_src[2] = 1'b0;
            tick();
            chk_int("edge_int_model");
            chk("edge_int_lat", {15'd0, int_b}, (k == 3) ? 16'd0 : 16'd1);
        end
        rd_lit("edge_pend", 3'd0, 16'h0004);
        rd_lit("edge_id", 3'd3, 16'h8002);
        wr(3'd0, 16'h0004);
        chk("clr_int_hold", {15'd0, int_b}, 16'd0);
        tick();
        chk("clr_int_high", {15'd0, int_b}, 16'd1);
        rd_lit("clr_id", 3'd3, 16'h0000);

        // Priority
        wr(3'd1, 16'h00FF);
        irq_src[5] = 1'b1; irq_src[1] = 1'b1;
        repeat (4) tick();
        rd_lit("prio_id", 3'd3, 16'h8001);
        wr(3'd0, 16'h0002);
        rd_lit("prio_id2", 3'd3, 16'h8005);
        chk("prio_int", {15'd0, int_b}, 16'd0);
        irq_src = '0;
        wr(3'd0, 16'h0020);
        repeat (2) tick();
        chk_int("prio_int_clr");

        // Level mode on source 0
        wr(3'd2, 16'h0000);
        wr(3'd1, 16'h0001);
        irq_src[0] = 1'b1;
        repeat (4) tick();
        wr(3'd0, 16'h0001);
        rd_lit("lvl_pend", 3'd0, 16'h0001);
        rd("lvl_pend_m", 3'd0);
        irq_src[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("lvl_int_drop", {15'd0, int_b}, (k == 3) ? 16'd1 : 16'd0);
        end
        rd_lit("lvl_pend0", 3'd0, 16'h0000);

        // Race: edge on source 3 meets a PENDING clear of the same bit
        wr(3'd2, 16'h00FF);
        wr(3'd1, 16'h0008);
        irq_src[3] = 1'b1;
        repeat (2) tick();
        wr(3'd0, 16'h0008);
        address = BASE; rnw = 1'b1; vda = 1'b1; #1;
        chk("race_bit", rdata & 16'h0008, 16'h0008);
        chk("race_pend_m", rdata, exp_rd(3'd0));
        tick(); vda = 1'b0;
        irq_src[3] = 1'b0;
        wr(3'd0, 16'h0008);
        repeat (2) tick();

        // Stall: write ignored, edge still captured
        clken = 1'b0;
        wr(3'd1, 16'h0040);
        irq_src[6] = 1'b1;
        repeat (4) tick();
        clken = 1'b1;
        rd_lit("stall_mask", 3'd1, 16'h0008);
        address = BASE; rnw = 1'b1; vda = 1'b1; #1;
        chk("stall_pend", rdata & 16'h0040, 16'h0040);
        tick(); vda = 1'b0;
        irq_src[6] = 1'b0;

        // Software set
        wr(3'd4, 16'h0010);
        wr(3'd1, 16'h0010);
`ifdef OPC5LS_INTC_SOFTSET_EN
        rd_lit("soft_id", 3'd3, 16'h8004);
        chk("soft_int", {15'd0, int_b}, 16'd0);
`else
        rd_lit("soft_id", 3'd3, 16'h0000);
`endif
        rd_lit("soft_rd4", 3'd4, 16'h0000);
        chk_int("soft_int_m");

        // Asynchronous reset mid-operation
        address = BASE; rnw = 1'b1; vda = 1'b1;
        reset_b = 1'b0; #1;
        chk("arst_pend", rdata, 16'h0000);
        chk("arst_int", {15'd0, int_b}, 16'd1);
        address = BASE | 16'd2; #1;
        chk("arst_mode", rdata, 16'h00FF);
        @(negedge clk);
        vda = 1'b0; reset_b = 1'b1;
        model_reset();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NSRC; i++)
                if ($urandom_range(0, 5) == 0) irq_src[i] = ~irq_src[i];
            clken = ($urandom_range(0, 4) != 0);
            case ($urandom_range(0, 3))
                0: begin
                    r = 16'($urandom);
                    address = BASE | 16'($urandom_range(0, 7));
                    if ($urandom_range(0, 2) == 0) r = r & 16'h00FF & ~16'(irq_src);
                    wr(address[2:0], r);
                end
                1: rd("rnd_rd", 3'($urandom_range(0, 7)));
                2: begin
                    address = 16'hFE00 | 16'($urandom_range(0, 255));
                    vda = 1'b1; rnw = 1'(($urandom_range(0, 1)));
                    tick();
                    vda = 1'b0; rnw = 1'b1;
                end
                default: tick();
            endcase
            chk_int("rnd_int");
        end
        clken = 1'b1;
        rd("rnd_end_pend", 3'd0);
        rd("rnd_end_id", 3'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/opc5ls_intc.md
# opc5ls_intc

Memory-mapped interrupt controller sitting directly upstream of the OPC5LS CPU's `int_b` input and on its data bus. It collects up to `NSRC` external interrupt sources and synchronises them. It latches them as pending, masks them, and resolves their priority, then drives the CPU's single active-low interrupt request. Software reads the winning source ID and acknowledges it through a small register window.

## Interface
Parameters:
- `NSRC`, 8, number of interrupt sources (1..15).
- `BASE_ADDR`, 16'hFF00, base of the 8-word register window; must be 8-aligned.

Ports:
- `clk`  in  1  system clock, same clock as the CPU.
- `reset_b`  in  1  reset; one clock, asynchronous and active-low.
- `clken`  in  1  bus-cycle qualifier, same signal the CPU uses.
- `address`  in  16  CPU address.
- `wdata`  in  16  CPU `dout`.
- `rnw`  in  1  CPU read-not-write.
- `vda`  in  1  CPU valid data address.
- `rdata`  out  16  read data; 0 when the block is not selected.
- `rsel`  out  1  high while a selected read is in progress; drives the system read-data mux.
- `irq_src`  in  NSRC  raw asynchronous interrupt sources, active-high.
- `int_b`  out  1  registered interrupt request to the CPU, active-low.

## Operation
- Select: `sel = vda && address[15:3]==BASE_ADDR[15:3]`. The register offset is `address[2:0]`.
- Register map. Unused bits read 0; unlisted offsets read 0 and ignore writes.
  - 0 PENDING: read gives pending bits. Writing 1 to a bit clears it (edge-mode sources only).
  - 1 MASK: read/write. 1 enables the source.
  - 2 MODE: read/write. 1 = edge-triggered, 0 = level-sensitive.
  - 3 ID: read-only. Returns `{bit15=valid, bits3:0=index}` of the lowest-numbered pending & masked source. Returns 0 when none is pending.
  - 4 SET: present only with the configuration macro (see Configuration).
- Synchroniser: two-flop chain per source, plus a third flop for edge detection. These run every `clk`, independent of `clken`.
- Edge mode: a rising edge of the synchronised source sets its pending bit. The bit holds until cleared by a PENDING write.
- Level mode: the pending bit equals the synchronised level every cycle. PENDING writes have no effect on it.
- Writes commit on `clk` rising edge when `clken && sel && !rnw`.
- Reads are combinational: `rdata` and `rsel` are valid while `sel && rnw`.
- Priority: lowest index wins.
- `int_b <= !(|(pending & mask))` registered every `clk`.

## Timing
- Reset (asynchronous on `reset_b` low): PENDING=0, MASK=0, MODE=all 1, synchroniser flops=0, `int_b`=1. `rdata`=0 and `rsel`=0 when not selected.
- Latency: source high before edge N gives the pending bit visible after edge N+2 and `int_b` low after edge N+3.
- Clear: PENDING write at edge M makes `int_b` return high after edge M+1, provided no other request is active.
- Simultaneous set and clear of the same bit in one cycle: the set wins and the bit stays 1.
- MASK write taking effect at edge M is reflected on `int_b` after edge M+1.
- `clken` low: bus writes are ignored. Source sampling and pending-setting continue, so edges are never lost.
- A source pulse shorter than one `clk` period may be missed. Software must guarantee at least 2 cycles high and 2 cycles low.
- MODE change edge→level: the pending bit immediately tracks the level. Change level→edge: the bit keeps its current value until cleared.
- Reset asserted mid-operation: all state clears asynchronously. Edges occurring during reset are discarded.

## Configuration
- `OPC5LS_INTC_SOFTSET_EN` defined: offset 4 SET is write-only and reads 0. Writing 1 to a bit sets that pending bit as a software interrupt. On edge-mode sources it behaves like a hardware edge. On level-mode sources it is overridden by the level next cycle. If SET and a PENDING clear hit the same bit in one cycle, SET wins.
- Not defined: offset 4 reads 0 and ignores writes; there is no SET logic.

## Test plan
- Reset: hold `reset_b`=0, then release → `int_b`=1; reads of offsets 0, 1, 2, 3 return 0000, 0000, 00FF, 0000.
- Edge interrupt: write MASK=0x0004 and pulse `irq_src[2]` high for 3 cycles → PENDING=0x0004, ID=0x8002, `int_b` low 3 cycles after the rise. Then write PENDING=0x0004 → `int_b` high after 1 cycle and ID=0x0000.
- Priority: MASK=0x00FF and raise sources 5 and 1 together → ID=0x8001. Clear bit 1 → ID=0x8005 and `int_b` stays low.
- Level mode: MODE=0x0000, MASK=0x0001, hold `irq_src[0]` high → a PENDING write of 0x0001 leaves PENDING=0x0001. Drop the source → PENDING=0 and `int_b` returns high 4 cycles later.
- Race: a `irq_src[3]` edge lands in the same cycle as a PENDING write of 0x0008 → the bit remains 1.
- Stall and softset: with `clken`=0, a MASK write is ignored but a source edge still sets pending. With the macro defined, SET=0x0010 and MASK=0x0010 → ID=0x8004 and `int_b` goes low.
